// File: rtl/alarm_controller_if.sv
// Timer handshake between the alarm controller (requester) and the countdown timer.
interface alarm_controller_if;
    logic       start_timer;
    logic [3:0] value;
    logic       expired;
    logic       one_hz_enable;

    modport master (output start_timer, value, input expired, one_hz_enable);
    modport slave  (input start_timer, value, output expired, one_hz_enable);
endinterface

// File: rtl/alarm_controller.sv
// Anti-theft alarm FSM: watches ignition and doors, programs the countdown timer,
// drives the siren and the status LED.
module alarm_controller #(
    parameter logic [3:0] T_ARM_DELAY       = 4'd6,
    parameter logic [3:0] T_DRIVER_DELAY    = 4'd8,
    parameter logic [3:0] T_PASSENGER_DELAY = 4'd15,
    parameter logic [3:0] T_ALARM_ON        = 4'd10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ignition,
    input  logic                door_driver,
    input  logic                door_pass,
    input  logic                reprogram,
    input  logic [1:0]          time_param_sel,
    input  logic [3:0]          time_value,
    alarm_controller_if.master  tmr,
    output logic                siren_on,
    output logic                status_led
);
    typedef enum logic [2:0] {
        ARMED           = 3'd0,
        TRIGGERED       = 3'd1,
        SOUND_ALARM     = 3'd2,
        DISARMED        = 3'd3,
        WAIT_DOOR_OPEN  = 3'd4,
        WAIT_DOOR_CLOSE = 3'd5,
        ARM_DELAY       = 3'd6
    } state_t;

    localparam logic [1:0] SEL_ARM = 2'd0, SEL_DRV = 2'd1, SEL_PAS = 2'd2, SEL_ALM = 2'd3;

    state_t     state;
    logic [3:0] tregs [4];
    logic [1:0] guard;
    logic [1:0] door_q;
    logic       in_armed_q;
    logic       exp_ok;
    logic       any_door;
    logic       door_opened;

    // A freshly loaded timer still shows its idle expired level for a couple of cycles.
    assign exp_ok      = tmr.expired && (guard == 2'd0);
    assign any_door    = door_driver || door_pass;
    assign door_opened = (door_driver && !door_q[1]) || (door_pass && !door_q[0]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= ARMED;
            tmr.start_timer <= 1'b0;
            tmr.value       <= 4'd0;
            siren_on        <= 1'b0;
            status_led      <= 1'b0;
            guard           <= 2'd0;
            door_q          <= 2'b00;
            in_armed_q      <= 1'b0;
            tregs[SEL_ARM]  <= T_ARM_DELAY;
            tregs[SEL_DRV]  <= T_DRIVER_DELAY;
            tregs[SEL_PAS]  <= T_PASSENGER_DELAY;
            tregs[SEL_ALM]  <= T_ALARM_ON;
        end else begin
            tmr.start_timer <= 1'b0;
            door_q          <= {door_driver, door_pass};
            in_armed_q      <= (state == ARMED);
            siren_on        <= (state == SOUND_ALARM);
            guard           <= (guard != 2'd0) ? guard - 2'd1 : 2'd0;

            // LED restarts from 0 on every entry into ARMED, then blinks at the timer's 1 Hz rate.
            case (state)
                ARMED:                  status_led <= (in_armed_q ? status_led : 1'b0) ^ tmr.one_hz_enable;
                TRIGGERED, SOUND_ALARM: status_led <= 1'b1;
                default:                status_led <= 1'b0;
            endcase

            if (reprogram) begin
                tregs[time_param_sel] <= time_value;
                state                 <= ARMED;
                guard                 <= 2'd0;
            end else if (ignition && state != DISARMED) begin
                state <= DISARMED;
            end else begin
                case (state)
                    ARMED: begin
                        if (door_driver) begin
                            tmr.start_timer <= 1'b1;
                            tmr.value       <= tregs[SEL_DRV];
                            guard           <= 2'd2;
                            state           <= TRIGGERED;
                        end else if (door_pass) begin
                            tmr.start_timer <= 1'b1;
                            tmr.value       <= tregs[SEL_PAS];
                            guard           <= 2'd2;
                            state           <= TRIGGERED;
                        end
                    end
                    TRIGGERED: begin
                        if (exp_ok) begin
                            tmr.start_timer <= 1'b1;
                            tmr.value       <= tregs[SEL_ALM];
                            guard           <= 2'd2;
                            state           <= SOUND_ALARM;
                        end
                    end
                    SOUND_ALARM: begin
                        if (any_door) begin
                            tmr.start_timer <= 1'b1;
                            tmr.value       <= tregs[SEL_ALM];
                            guard           <= 2'd2;
                        end else if (exp_ok) begin
                            state <= ARMED;
                        end
                    end
                    DISARMED: begin
                        if (!ignition) state <= WAIT_DOOR_OPEN;
                    end
                    WAIT_DOOR_OPEN: begin
                        if (door_driver) state <= WAIT_DOOR_CLOSE;
                    end
                    WAIT_DOOR_CLOSE: begin
                        if (!any_door) begin
                            tmr.start_timer <= 1'b1;
                            tmr.value       <= tregs[SEL_ARM];
                            guard           <= 2'd2;
                            state           <= ARM_DELAY;
                        end
                    end
                    ARM_DELAY: begin
                        if (door_opened) begin
                            tmr.start_timer <= 1'b1;
                            tmr.value       <= tregs[SEL_ARM];
                            guard           <= 2'd2;
                        end else if (exp_ok) begin
                            state <= ARMED;
                        end
                    end
                    default: state <= ARMED;
                endcase
            end
        end
    end
endmodule
